// File: rtl/pad_arb_pkg.sv
`default_nettype none
// ============================================================================
// Package     : pad_arb_pkg
// Description : Shared types for the pad bank OE arbiter: arbiter state
//               encoding, bank owner encoding, turnaround counter width and
//               a helper mapping an owner to its grant state.
// Revision    : 1.0 - initial release
// ============================================================================
package pad_arb_pkg;

    // Counter width for the turnaround countdown (TURN_CYCLES max 15)
    localparam int c_turn_cnt_w = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_A = 2'd1,
        GNT_B = 2'd2,
        TURN  = 2'd3
    } arb_state_t;

    typedef enum logic {
        OWN_A = 1'b0,
        OWN_B = 1'b1
    } owner_t;

    // Grant state that hands the bank to the given owner
    function automatic arb_state_t grant_state(input owner_t owner);
        return (owner == OWN_A) ? GNT_A : GNT_B;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pad_in_sync.sv
`default_nettype none
// ============================================================================
// Module      : pad_in_sync
// Description : NPADS-wide, SYNC_STAGES-deep flop chain that brings the
//               asynchronous pad inputs into the clock domain. All stages
//               reset asynchronously to 0.
// Ports       : clk  - clock
//               rst  - asynchronous active-high reset
//               i_d  - asynchronous pad data
//               o_q  - synchronised data (SYNC_STAGES cycles latency)
// Revision    : 1.0 - initial release
// ============================================================================
module pad_in_sync #(
    parameter int NPADS       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NPADS-1:0] i_d,
    output logic [NPADS-1:0] o_q
);

    logic [NPADS-1:0] r_stage [SYNC_STAGES];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                r_stage[s] <= '0;
            end
        end else begin
            r_stage[0] <= i_d;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                r_stage[s] <= r_stage[s-1];
            end
        end
    end

    assign o_q = r_stage[SYNC_STAGES-1];

endmodule
`default_nettype wire

// File: rtl/pad_bank_oe_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : pad_bank_oe_arbiter
// Description : Shares one bank of bidirectional OE pads between requester A
//               (GPIO) and requester B (alternate function). The whole bank is
//               granted to one requester at a time, non-preemptively; every
//               handover passes through TURN_CYCLES of forced OE-low so two
//               drivers never overlap on a pad. Pad inputs are synchronised
//               and returned only to the current owner.
// Macro       : PADARB_CONTENTION_DETECT_EN - when defined, the driven pad
//               value is delayed to line up with the synchronised pad input
//               and any pad driven for 2 consecutive cycles that reads back a
//               different level sets a sticky contention_err bit. When
//               undefined, contention_err is tied 0 and err_clr is ignored.
// Ports       : HCLK, HRESET (async, active-high)
//               a_req/a_gnt/a_o/a_oe/a_i - requester A
//               b_req/b_gnt/b_o/b_oe/b_i - requester B
//               pad_o/pad_oe/pad_i       - pad bank nets
//               busy                     - arbiter not idle
//               err_clr/contention_err   - sticky per-pad contention flags
// Revision    : 1.0 - initial release
// ============================================================================
module pad_bank_oe_arbiter
    import pad_arb_pkg::*;
#(
    parameter int NPADS       = 16,
    parameter int TURN_CYCLES = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic             HCLK,
    input  logic             HRESET,
    input  logic             a_req,
    output logic             a_gnt,
    input  logic [NPADS-1:0] a_o,
    input  logic [NPADS-1:0] a_oe,
    output logic [NPADS-1:0] a_i,
    input  logic             b_req,
    output logic             b_gnt,
    input  logic [NPADS-1:0] b_o,
    input  logic [NPADS-1:0] b_oe,
    output logic [NPADS-1:0] b_i,
    output logic [NPADS-1:0] pad_o,
    output logic [NPADS-1:0] pad_oe,
    input  logic [NPADS-1:0] pad_i,
    output logic             busy,
    input  logic             err_clr,
    output logic [NPADS-1:0] contention_err
);

    localparam logic [c_turn_cnt_w-1:0] c_turn_load = c_turn_cnt_w'(TURN_CYCLES);
    localparam logic [c_turn_cnt_w-1:0] c_cnt_one   = c_turn_cnt_w'(1);

    arb_state_t              r_state;
    arb_state_t              w_state_nxt;
    owner_t                  r_last_owner;
    owner_t                  w_last_owner_nxt;
    logic [c_turn_cnt_w-1:0] r_cnt;
    logic [c_turn_cnt_w-1:0] w_cnt_nxt;
    logic                    r_a_gnt;
    logic                    r_b_gnt;
    logic [NPADS-1:0]        r_pad_o;
    logic [NPADS-1:0]        w_pad_o_nxt;
    logic [NPADS-1:0]        r_pad_oe;
    logic [NPADS-1:0]        w_pad_oe_nxt;
    logic [NPADS-1:0]        w_sync;

    // ------------------------------------------------------------------------
    // State / output registers. Async reset drops pad_oe immediately so the
    // pads are released the instant HRESET rises, not at the next edge.
    // ------------------------------------------------------------------------
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            r_state      <= IDLE;
            r_last_owner <= OWN_B;
            r_cnt        <= '0;
            r_a_gnt      <= 1'b0;
            r_b_gnt      <= 1'b0;
            r_pad_o      <= '0;
            r_pad_oe     <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_last_owner <= w_last_owner_nxt;
            r_cnt        <= w_cnt_nxt;
            r_a_gnt      <= (w_state_nxt == GNT_A);
            r_b_gnt      <= (w_state_nxt == GNT_B);
            r_pad_o      <= w_pad_o_nxt;
            r_pad_oe     <= w_pad_oe_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and next pad drive. pad_oe defaults low so any state other
    // than a continuing grant releases the bank; pad_o simply holds.
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt      = r_state;
        w_last_owner_nxt = r_last_owner;
        w_cnt_nxt        = r_cnt;
        w_pad_o_nxt      = r_pad_o;
        w_pad_oe_nxt     = '0;

        case (r_state)
            IDLE: begin
                if (a_req && b_req) begin
                    // Tie goes to whoever did not own the bank last
                    w_state_nxt = (r_last_owner == OWN_B) ? grant_state(OWN_A)
                                                          : grant_state(OWN_B);
                end else if (a_req) begin
                    w_state_nxt = GNT_A;
                end else if (b_req) begin
                    w_state_nxt = GNT_B;
                end
            end
            GNT_A: begin
                if (a_req) begin
                    w_pad_o_nxt  = a_o;
                    w_pad_oe_nxt = a_oe;
                end else begin
                    w_state_nxt      = TURN;
                    w_last_owner_nxt = OWN_A;
                    w_cnt_nxt        = c_turn_load;
                end
            end
            GNT_B: begin
                if (b_req) begin
                    w_pad_o_nxt  = b_o;
                    w_pad_oe_nxt = b_oe;
                end else begin
                    w_state_nxt      = TURN;
                    w_last_owner_nxt = OWN_B;
                    w_cnt_nxt        = c_turn_load;
                end
            end
            TURN: begin
                // Requests are ignored; arbitration resumes from IDLE
                w_cnt_nxt = r_cnt - c_cnt_one;
                if (r_cnt == c_cnt_one) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Input synchroniser; only the current owner sees pad data
    // ------------------------------------------------------------------------
    pad_in_sync #(
        .NPADS       (NPADS),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_pad_in_sync (
        .clk (HCLK),
        .rst (HRESET),
        .i_d (pad_i),
        .o_q (w_sync)
    );

    assign a_gnt  = r_a_gnt;
    assign b_gnt  = r_b_gnt;
    assign a_i    = r_a_gnt ? w_sync : '0;
    assign b_i    = r_b_gnt ? w_sync : '0;
    assign pad_o  = r_pad_o;
    assign pad_oe = r_pad_oe;
    assign busy   = (r_state != IDLE);

`ifdef PADARB_CONTENTION_DETECT_EN
    // ------------------------------------------------------------------------
    // Contention checker. The driven value is delayed by the synchroniser
    // depth so it is compared against the read-back of the same cycle. The
    // two-cycle OE qualifier masks the first cycle after OE rises, when the
    // pad may still be slewing from its previous level.
    // ------------------------------------------------------------------------
    logic [NPADS-1:0] r_o_dly  [SYNC_STAGES];
    logic [NPADS-1:0] r_oe_dly [SYNC_STAGES];
    logic [NPADS-1:0] r_oe_prev;
    logic [NPADS-1:0] r_err;
    logic [NPADS-1:0] w_o_d;
    logic [NPADS-1:0] w_oe_d;
    logic [NPADS-1:0] w_clash;

    assign w_o_d   = r_o_dly[SYNC_STAGES-1];
    assign w_oe_d  = r_oe_dly[SYNC_STAGES-1];
    assign w_clash = w_oe_d & r_oe_prev & (w_sync ^ w_o_d);

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                r_o_dly[s]  <= '0;
                r_oe_dly[s] <= '0;
            end
            r_oe_prev <= '0;
            r_err     <= '0;
        end else begin
            r_o_dly[0]  <= r_pad_o;
            r_oe_dly[0] <= r_pad_oe;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                r_o_dly[s]  <= r_o_dly[s-1];
                r_oe_dly[s] <= r_oe_dly[s-1];
            end
            r_oe_prev <= w_oe_d;
            // A new clash in the same cycle as err_clr keeps the flag set
            r_err     <= (err_clr ? '0 : r_err) | w_clash;
        end
    end

    assign contention_err = r_err;
`else
    logic w_unused_err_clr;

    assign w_unused_err_clr = err_clr;
    assign contention_err   = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pad_bank_oe_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_pad_bank_oe_arbiter
// Description : Directed self-checking bench for pad_bank_oe_arbiter.
//               Expected values are queued when stimulus is applied and
//               popped against DUT outputs one cycle-sample later.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pad_bank_oe_arbiter;

    localparam int NPADS = 16;

    logic             HCLK = 1'b0;
    logic             HRESET;
    logic             a_req, b_req;
    logic             a_gnt, b_gnt;
    logic [NPADS-1:0] a_o, a_oe, a_i;
    logic [NPADS-1:0] b_o, b_oe, b_i;
    logic [NPADS-1:0] pad_o, pad_oe, pad_i;
    logic             busy;
    logic             err_clr;
    logic [NPADS-1:0] contention_err;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } exp_t;

    exp_t sb_q[$];

    pad_bank_oe_arbiter #(
        .NPADS       (NPADS),
        .TURN_CYCLES (2),
        .SYNC_STAGES (2)
    ) dut (
        .HCLK           (HCLK),
        .HRESET         (HRESET),
        .a_req          (a_req),
        .a_gnt          (a_gnt),
        .a_o            (a_o),
        .a_oe           (a_oe),
        .a_i            (a_i),
        .b_req          (b_req),
        .b_gnt          (b_gnt),
        .b_o            (b_o),
        .b_oe           (b_oe),
        .b_i            (b_i),
        .pad_o          (pad_o),
        .pad_oe         (pad_oe),
        .pad_i          (pad_i),
        .busy           (busy),
        .err_clr        (err_clr),
        .contention_err (contention_err)
    );

    always #5 HCLK = ~HCLK;

    task automatic tick(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge HCLK);
            #1;
        end
    endtask

    task automatic sb_push(input string tag, input logic [31:0] exp);
        exp_t e;
        e.tag = tag;
        e.exp = exp;
        sb_q.push_back(e);
    endtask

    task automatic sb_pop(input logic [31:0] obs);
        exp_t e;
        checks++;
        if (sb_q.size() == 0) begin
            failures++;
            $display("FAIL scoreboard_empty observed=%h expected=<none>", obs);
        end else begin
            e = sb_q.pop_front();
            assert (obs === e.exp) else begin
                failures++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        HRESET  = 1'b1;
        a_req   = 1'b1;
        b_req   = 1'b1;
        a_o     = 16'h1234;
        a_oe    = 16'h00FF;
        b_o     = 16'h0000;
        b_oe    = 16'h0000;
        pad_i   = 16'h0000;
        err_clr = 1'b0;

        // Reset with both requesting: everything quiet
        tick(2);
        sb_push("rst_a_gnt", 32'd0);           sb_pop({31'd0, a_gnt});
        sb_push("rst_b_gnt", 32'd0);           sb_pop({31'd0, b_gnt});
        sb_push("rst_pad_oe", 32'd0);          sb_pop({16'd0, pad_oe});
        sb_push("rst_pad_o", 32'd0);           sb_pop({16'd0, pad_o});
        sb_push("rst_a_i", 32'd0);             sb_pop({16'd0, a_i});
        sb_push("rst_busy", 32'd0);            sb_pop({31'd0, busy});
        sb_push("rst_cerr", 32'd0);            sb_pop({16'd0, contention_err});

        // Release: tie from reset goes to A (last owner is B)
        HRESET = 1'b0;
        sb_push("rel_a_gnt", 32'd1);
        sb_push("rel_b_gnt", 32'd0);
        sb_push("rel_pad_oe_early", 32'd0);
        sb_push("rel_busy", 32'd1);
        tick();
        sb_pop({31'd0, a_gnt});
        sb_pop({31'd0, b_gnt});
        sb_pop({16'd0, pad_oe});
        sb_pop({31'd0, busy});
        sb_push("grant_pad_oe", 32'h0000_00FF);
        sb_push("grant_pad_o", 32'h0000_1234);
        tick();
        sb_pop({16'd0, pad_oe});
        sb_pop({16'd0, pad_o});

        // A holds the bank; B keeps requesting and must stay locked out
        a_o   = 16'hA5A5;
        a_oe  = 16'hFFFF;
        pad_i = 16'hA5A5;
        for (int k = 0; k < 3; k++) begin
            sb_push("hold_pad_o", 32'h0000_A5A5);
            sb_push("hold_pad_oe", 32'h0000_FFFF);
            sb_push("hold_b_gnt", 32'd0);
            sb_push("hold_b_i", 32'd0);
            tick();
            sb_pop({16'd0, pad_o});
            sb_pop({16'd0, pad_oe});
            sb_pop({31'd0, b_gnt});
            sb_pop({16'd0, b_i});
        end

        // Input path latency: old value for one more cycle, new after two
        a_oe  = 16'h0000;
        pad_i = 16'h00F0;
        sb_push("sync_a_i_old", 32'h0000_A5A5);
        tick();
        sb_pop({16'd0, a_i});
        sb_push("sync_a_i_new", 32'h0000_00F0);
        sb_push("sync_b_i", 32'd0);
        tick();
        sb_pop({16'd0, a_i});
        sb_pop({16'd0, b_i});

        // Contention: drive pad 3 high while its read-back stays low
        tick(4);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        sb_push("cerr_cleared", 32'd0);
        sb_pop({16'd0, contention_err});
        a_o   = 16'h0008;
        a_oe  = 16'h0008;
        pad_i = 16'h0000;
        tick(6);
`ifdef PADARB_CONTENTION_DETECT_EN
        sb_push("cerr_set", 32'h0000_0008);
`else
        sb_push("cerr_tied0", 32'd0);
`endif
        sb_pop({16'd0, contention_err});
        // Clear while the clash persists: the set must win
        err_clr = 1'b1;
        tick(2);
`ifdef PADARB_CONTENTION_DETECT_EN
        sb_push("cerr_set_wins", 32'h0000_0008);
`else
        sb_push("cerr_clr_ignored", 32'd0);
`endif
        sb_pop({16'd0, contention_err});
        // Clash removed: err_clr now empties the flag
        pad_i = 16'h0008;
        tick(4);
        sb_push("cerr_clr", 32'd0);
        sb_pop({16'd0, contention_err});
        err_clr = 1'b0;

        // Handover A -> B
        a_o   = 16'h1111;
        a_oe  = 16'hFFFF;
        pad_i = 16'h1111;
        tick(2);
        sb_push("pre_ho_pad_oe", 32'h0000_FFFF);
        sb_pop({16'd0, pad_oe});
        a_req = 1'b0;
        b_o   = 16'h5A5A;
        b_oe  = 16'hFFFF;
        sb_push("ho_pad_oe_low", 32'd0);
        sb_push("ho_a_gnt", 32'd0);
        sb_push("ho_pad_o_held", 32'h0000_1111);
        sb_push("ho_busy", 32'd1);
        tick();
        sb_pop({16'd0, pad_oe});
        sb_pop({31'd0, a_gnt});
        sb_pop({16'd0, pad_o});
        sb_pop({31'd0, busy});
        pad_i = 16'h5A5A;
        for (int k = 0; k < 2; k++) begin
            sb_push("turn_b_gnt", 32'd0);
            sb_push("turn_pad_oe", 32'd0);
            tick();
            sb_pop({31'd0, b_gnt});
            sb_pop({16'd0, pad_oe});
        end
        sb_push("ho_b_gnt", 32'd1);
        sb_push("ho_pad_oe_still_low", 32'd0);
        tick();
        sb_pop({31'd0, b_gnt});
        sb_pop({16'd0, pad_oe});
        sb_push("b_pad_oe", 32'h0000_FFFF);
        sb_push("b_pad_o", 32'h0000_5A5A);
        sb_push("b_b_i", 32'h0000_5A5A);
        sb_push("b_a_i", 32'd0);
        tick();
        sb_pop({16'd0, pad_oe});
        sb_pop({16'd0, pad_o});
        sb_pop({16'd0, b_i});
        sb_pop({16'd0, a_i});

        // Asynchronous reset mid-grant releases pads before the next edge
        #2;
        HRESET = 1'b1;
        #1;
        sb_push("arst_pad_oe", 32'd0);
        sb_push("arst_busy", 32'd0);
        sb_push("arst_b_gnt", 32'd0);
        sb_push("arst_b_i", 32'd0);
        sb_pop({16'd0, pad_oe});
        sb_pop({31'd0, busy});
        sb_pop({31'd0, b_gnt});
        sb_pop({16'd0, b_i});

        // Only B requesting after reset: B granted
        tick();
        HRESET = 1'b0;
        sb_push("post_b_gnt", 32'd1);
        sb_push("post_a_gnt", 32'd0);
        tick();
        sb_pop({31'd0, b_gnt});
        sb_pop({31'd0, a_gnt});

        if (sb_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_leftover observed=%0d expected=0", sb_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
